// File: rtl/recv_pkt.sv
// recv_pkt: per-node receive checker placed after the ring router's PE port.
// It collects one packet from each expected source, validates each packet's
// destination, format and source, and reports completion, a verdict and sticky
// error flags for the current phase.
module recv_pkt #(
  parameter logic [1:0] NODE_ID = 2'd0,
  parameter int         TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,       // asynchronous, active-low
  input  logic        start,
  input  logic [3:0]  exp_mask,
  input  logic        peso,
  input  logic [63:0] pedo,
  output logic        pero,
  output logic        done,
  output logic        pass,
  output logic [3:0]  rcv_mask,
  output logic [3:0]  err_flags,
  output logic [7:0]  pkt_cnt,
  output logic [63:0] last_pkt,
  output logic        last_valid
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Timer value on the last COLLECT cycle a phase is allowed.
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  state_t      r_state, w_state_next;
  logic        r_pero;
  logic        r_done, w_done_next;
  logic        r_pass, w_pass_next;
  logic [3:0]  r_exp_mask, w_exp_mask_next;
  logic [3:0]  r_rcv_mask, w_rcv_mask_next;
  logic [3:0]  r_err, w_err_next;
  logic [7:0]  r_pkt_cnt, w_pkt_cnt_next;
  logic [63:0] r_last_pkt, w_last_pkt_next;
  logic        r_last_valid, w_last_valid_next;
  logic [15:0] r_timer, w_timer_next;

  logic        w_accept;
  logic        w_fmt_err;
  logic [1:0]  w_src;
  logic [3:0]  w_rcv_upd;
  logic [3:0]  w_err_upd;

  // A packet is taken only while collecting and the ready register is high.
  assign w_accept  = (r_state == ST_COLLECT) && peso && r_pero;
  assign w_src     = pedo[33:32];
  assign w_fmt_err = (|pedo[61:50]) || (|pedo[31:2]) || (pedo[47:32] > 16'd3);

  // Effect of the presented packet on the receive mask and the error flags.
  always_comb begin
    w_rcv_upd = r_rcv_mask;
    w_err_upd = r_err;
    if (pedo[1:0] != NODE_ID) begin
      w_err_upd[0] = 1'b1;
    end
    if (w_fmt_err) begin
      // Malformed packets never credit a source.
      w_err_upd[1] = 1'b1;
    end else if (r_rcv_mask[w_src] || !r_exp_mask[w_src]) begin
      w_err_upd[2] = 1'b1;
    end else begin
      w_rcv_upd[w_src] = 1'b1;
    end
  end

  // Next-state and next-value logic for the phase controller and datapath.
  always_comb begin
    w_state_next      = r_state;
    w_done_next       = r_done;
    w_pass_next       = r_pass;
    w_exp_mask_next   = r_exp_mask;
    w_rcv_mask_next   = r_rcv_mask;
    w_err_next        = r_err;
    w_pkt_cnt_next    = r_pkt_cnt;
    w_last_pkt_next   = r_last_pkt;
    w_last_valid_next = 1'b0;
    w_timer_next      = r_timer;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        // DONE restarts directly on start, exactly like IDLE does.
        if (start) begin
          w_exp_mask_next = exp_mask;
          w_rcv_mask_next = 4'd0;
          w_err_next      = 4'd0;
          w_pkt_cnt_next  = 8'd0;
          w_timer_next    = 16'd0;
          if (exp_mask == 4'd0) begin
            // Nothing to wait for: the phase is trivially complete.
            w_state_next = ST_DONE;
            w_done_next  = 1'b1;
            w_pass_next  = 1'b1;
          end else begin
            w_state_next = ST_COLLECT;
            w_done_next  = 1'b0;
            w_pass_next  = 1'b0;
          end
        end
      end

      ST_COLLECT: begin
        logic [3:0] v_rcv;
        logic [3:0] v_err;
        v_rcv = r_rcv_mask;
        v_err = r_err;
        if (w_accept) begin
          v_rcv             = w_rcv_upd;
          v_err             = w_err_upd;
          w_last_pkt_next   = pedo;
          w_last_valid_next = 1'b1;
          if (r_pkt_cnt != 8'hFF) begin
            w_pkt_cnt_next = r_pkt_cnt + 8'd1;
          end
        end
        w_rcv_mask_next = v_rcv;
        // Completion takes priority over a timeout on the same edge.
        if (v_rcv == r_exp_mask) begin
          w_state_next = ST_DONE;
          w_done_next  = 1'b1;
          w_pass_next  = (v_err == 4'd0);
          w_err_next   = v_err;
        end else if (r_timer == TIMER_LAST) begin
          w_state_next = ST_DONE;
          w_done_next  = 1'b1;
          w_pass_next  = 1'b0;
          w_err_next   = v_err | 4'b1000;
        end else begin
          w_err_next   = v_err;
          w_timer_next = r_timer + 16'd1;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Phase state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath and status registers; ready tracks the COLLECT state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pero       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_exp_mask   <= 4'd0;
      r_rcv_mask   <= 4'd0;
      r_err        <= 4'd0;
      r_pkt_cnt    <= 8'd0;
      r_last_pkt   <= 64'd0;
      r_last_valid <= 1'b0;
      r_timer      <= 16'd0;
    end else begin
      r_pero       <= (w_state_next == ST_COLLECT);
      r_done       <= w_done_next;
      r_pass       <= w_pass_next;
      r_exp_mask   <= w_exp_mask_next;
      r_rcv_mask   <= w_rcv_mask_next;
      r_err        <= w_err_next;
      r_pkt_cnt    <= w_pkt_cnt_next;
      r_last_pkt   <= w_last_pkt_next;
      r_last_valid <= w_last_valid_next;
      r_timer      <= w_timer_next;
    end
  end

  assign pero       = r_pero;
  assign done       = r_done;
  assign pass       = r_pass;
  assign rcv_mask   = r_rcv_mask;
  assign err_flags  = r_err;
  assign pkt_cnt    = r_pkt_cnt;
  assign last_pkt   = r_last_pkt;
  assign last_valid = r_last_valid;

endmodule

// File: tb/tb_recv_pkt.sv
// Directed bench for recv_pkt (NODE_ID=2, TIMEOUT=16).
module tb_recv_pkt;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  exp_mask;
  logic        peso;
  logic [63:0] pedo;
  logic        pero;
  logic        done;
  logic        pass;
  logic [3:0]  rcv_mask;
  logic [3:0]  err_flags;
  logic [7:0]  pkt_cnt;
  logic [63:0] last_pkt;
  logic        last_valid;

  int total;
  int bad;

  recv_pkt #(
    .NODE_ID (2'd2),
    .TIMEOUT (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .exp_mask   (exp_mask),
    .peso       (peso),
    .pedo       (pedo),
    .pero       (pero),
    .done       (done),
    .pass       (pass),
    .rcv_mask   (rcv_mask),
    .err_flags  (err_flags),
    .pkt_cnt    (pkt_cnt),
    .last_pkt   (last_pkt),
    .last_valid (last_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Build a packet: vc/dir/hop zero, reserved fields zero.
  function automatic logic [63:0] mkpkt(input logic [15:0] src, input logic [1:0] dst);
    mkpkt = {2'b00, 12'd0, 2'b00, src, 30'd0, dst};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] p);
    peso = 1'b1;
    pedo = p;
    tick();
    $display("pkt sent=%016h cnt=%0d rcv=%b err=%b done=%b", p, pkt_cnt, rcv_mask, err_flags, done);
  endtask

  task automatic pulse_start(input logic [3:0] m);
    start    = 1'b1;
    exp_mask = m;
    tick();
    start    = 1'b0;
    $display("start exp_mask=%b pero=%b done=%b", m, pero, done);
  endtask

  initial begin
    logic [63:0] bad_fmt;
    total    = 0;
    bad      = 0;
    reset    = 1'b0;
    start    = 1'b0;
    exp_mask = 4'd0;
    peso     = 1'b0;
    pedo     = 64'd0;
    #1;
    check("rst_pero", 64'(pero), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_pass", 64'(pass), 64'd0);
    check("rst_rcv", 64'(rcv_mask), 64'd0);
    check("rst_err", 64'(err_flags), 64'd0);
    check("rst_cnt", 64'(pkt_cnt), 64'd0);
    check("rst_last", last_pkt, 64'd0);
    tick();
    tick();
    reset = 1'b1;

    // peso in IDLE must not be accepted.
    peso = 1'b1;
    pedo = mkpkt(16'd0, 2'd2);
    tick();
    tick();
    check("idle_cnt", 64'(pkt_cnt), 64'd0);
    check("idle_pero", 64'(pero), 64'd0);
    check("idle_lv", 64'(last_valid), 64'd0);
    peso = 1'b0;

    // Test 1: expect sources 0,1,3; exp_mask changes after start are ignored.
    pulse_start(4'b1011);
    exp_mask = 4'b0000;
    check("t1_pero_on", 64'(pero), 64'd1);
    check("t1_done0", 64'(done), 64'd0);
    send(mkpkt(16'd0, 2'd2));
    check("t1_rcv1", 64'(rcv_mask), 64'b0001);
    check("t1_cnt1", 64'(pkt_cnt), 64'd1);
    check("t1_lv", 64'(last_valid), 64'd1);
    check("t1_last", last_pkt, mkpkt(16'd0, 2'd2));
    send(mkpkt(16'd1, 2'd2));
    check("t1_done_mid", 64'(done), 64'd0);
    send(mkpkt(16'd3, 2'd2));
    check("t1_rcv", 64'(rcv_mask), 64'b1011);
    check("t1_cnt", 64'(pkt_cnt), 64'd3);
    check("t1_done", 64'(done), 64'd1);
    check("t1_pass", 64'(pass), 64'd1);
    check("t1_err", 64'(err_flags), 64'd0);
    check("t1_pero_off", 64'(pero), 64'd0);
    // peso held in DONE: no further accepts.
    send(mkpkt(16'd2, 2'd2));
    check("done_cnt", 64'(pkt_cnt), 64'd3);
    check("done_lv", 64'(last_valid), 64'd0);
    check("done_last", last_pkt, mkpkt(16'd3, 2'd2));
    check("done_hold", 64'(done), 64'd1);
    peso = 1'b0;

    // Test 2: duplicate source; restart directly from DONE.
    pulse_start(4'b0011);
    check("t2_done_clr", 64'(done), 64'd0);
    check("t2_pass_clr", 64'(pass), 64'd0);
    check("t2_cnt_clr", 64'(pkt_cnt), 64'd0);
    check("t2_rcv_clr", 64'(rcv_mask), 64'd0);
    send(mkpkt(16'd0, 2'd2));
    check("t2_err_first", 64'(err_flags), 64'd0);
    send(mkpkt(16'd0, 2'd2));
    check("t2_err_dup", 64'(err_flags), 64'b0100);
    send(mkpkt(16'd1, 2'd2));
    check("t2_done", 64'(done), 64'd1);
    check("t2_pass", 64'(pass), 64'd0);
    check("t2_cnt", 64'(pkt_cnt), 64'd3);
    check("t2_rcv", 64'(rcv_mask), 64'b0011);
    peso = 1'b0;

    // Test 3: dst mismatch and malformed source field.
    pulse_start(4'b0011);
    send(mkpkt(16'd0, 2'd1));
    check("t3_err_dst", 64'(err_flags), 64'b0001);
    check("t3_rcv_dst", 64'(rcv_mask), 64'b0001);
    bad_fmt = mkpkt(16'h0100, 2'd2);
    send(bad_fmt);
    check("t3_err_fmt", 64'(err_flags), 64'b0011);
    check("t3_rcv_fmt", 64'(rcv_mask), 64'b0001);
    check("t3_last_fmt", last_pkt, bad_fmt);
    check("t3_done_mid", 64'(done), 64'd0);
    send(mkpkt(16'd1, 2'd2));
    check("t3_done", 64'(done), 64'd1);
    check("t3_pass", 64'(pass), 64'd0);
    check("t3_err_end", 64'(err_flags), 64'b0011);
    peso = 1'b0;

    // Test 4a: timeout with no traffic after 16 COLLECT cycles.
    pulse_start(4'b0001);
    for (int i = 0; i < 15; i++) tick();
    check("t4_done_early", 64'(done), 64'd0);
    check("t4_pero_early", 64'(pero), 64'd1);
    tick();
    $display("timeout phase done=%b err=%b pass=%b", done, err_flags, pass);
    check("t4_done", 64'(done), 64'd1);
    check("t4_err", 64'(err_flags), 64'b1000);
    check("t4_pass", 64'(pass), 64'd0);
    check("t4_pero", 64'(pero), 64'd0);

    // Test 4b: completing packet on the final timeout cycle wins.
    pulse_start(4'b0001);
    for (int i = 0; i < 15; i++) tick();
    send(mkpkt(16'd0, 2'd2));
    check("t4b_done", 64'(done), 64'd1);
    check("t4b_err", 64'(err_flags), 64'd0);
    check("t4b_pass", 64'(pass), 64'd1);
    peso = 1'b0;

    // Test 5: reset mid-COLLECT clears everything immediately.
    pulse_start(4'b0011);
    send(mkpkt(16'd0, 2'd2));
    peso = 1'b0;
    check("t5_pre_cnt", 64'(pkt_cnt), 64'd1);
    reset = 1'b0;
    #1;
    $display("async reset pero=%b cnt=%0d rcv=%b", pero, pkt_cnt, rcv_mask);
    check("t5_pero", 64'(pero), 64'd0);
    check("t5_cnt", 64'(pkt_cnt), 64'd0);
    check("t5_rcv", 64'(rcv_mask), 64'd0);
    check("t5_lv", 64'(last_valid), 64'd0);
    check("t5_last", last_pkt, 64'd0);
    reset = 1'b1;
    tick();
    check("t5_idle_pero", 64'(pero), 64'd0);

    // Test 6: empty expected mask finishes at once with pass.
    pulse_start(4'b0000);
    check("t6_done", 64'(done), 64'd1);
    check("t6_pass", 64'(pass), 64'd1);
    check("t6_pero", 64'(pero), 64'd0);
    tick();
    check("t6_pero_hold", 64'(pero), 64'd0);
    check("t6_done_hold", 64'(done), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
